// File: rtl/layer_boundary_skid.sv
// rtl/layer_boundary_skid.sv - registered two-entry valid/ready skid stage between LUT layers
module layer_boundary_skid #(
  parameter int NUM_NEURONS = 32,
  parameter int OUT_BITS    = 2,
  parameter int DATA_W      = NUM_NEURONS * OUT_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] main_data, main_next;
  logic [DATA_W-1:0] skid_data, skid_next;
  logic              valid_q, valid_next;
  logic              ready_q, ready_next;
  logic              in_xfer, out_xfer;

  // Handshakes use only flopped flags, so out_ready never reaches in_ready combinationally
  assign in_xfer  = in_valid & ready_q;
  assign out_xfer = valid_q & out_ready;

  always_comb begin
    state_next = state;
    main_next  = main_data;
    skid_next  = skid_data;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          main_next  = in_data;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_next = in_data;
        end else if (in_xfer) begin
          skid_next  = in_data;
          state_next = TWO;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_next  = skid_data;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    valid_next = (state_next != EMPTY);
    ready_next = (state_next != TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_next;
      main_data <= main_next;
      skid_data <= skid_next;
      valid_q   <= valid_next;
      ready_q   <= ready_next;
    end
  end

  assign out_data  = main_data;
  assign out_valid = valid_q;
  assign in_ready  = ready_q;
  assign occupancy = state;

endmodule

// File: tb/tb_layer_boundary_skid.sv
// tb/tb_layer_boundary_skid.sv - queue-model bench for layer_boundary_skid
module tb_layer_boundary_skid;
  localparam int NN = 32;
  localparam int OB = 2;
  localparam int W  = NN * OB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   occupancy;

  layer_boundary_skid #(.NUM_NEURONS(NN), .OUT_BITS(OB)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  logic [W-1:0] q[$];
  int vectors = 0;
  int miscompares = 0;
  bit data_zero = 1'b1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the queue model, check everything
  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      input logic ordy, output bit acc);
    bit           hold;
    logic [W-1:0] hold_data;
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    hold = out_valid && !ordy && !r;
    hold_data = out_data;
    @(posedge clk);
    vectors++;
    acc = 1'b0;
    if (r) begin
      q.delete();
      data_zero = 1'b1;
    end else begin
      acc = v && (q.size() < 2);
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) begin
        q.push_back(d);
        data_zero = 1'b0;
      end
    end
    #1;
    chk("out_valid", W'(out_valid), W'(q.size() > 0));
    chk("in_ready", W'(in_ready), W'(q.size() < 2));
    chk("occupancy", W'(occupancy), W'(q.size()));
    if (q.size() > 0) chk("out_data", out_data, q[0]);
    else if (data_zero) chk("out_data_reset", out_data, '0);
    chk("skid_without_main", W'(!in_ready && !out_valid), '0);
    if (hold) chk("stable_under_stall", out_data, hold_data);
  endtask

  initial begin
    bit           a;
    logic [W-1:0] src;
    bit           src_pending;

    // reset held for two cycles, then idle
    step(1, 1, {W{1'b1}}, 1, a);
    step(1, 1, {W{1'b1}}, 1, a);
    step(0, 0, '0, 0, a);

    // single pass-through
    step(0, 1, 64'hA5A5_0F0F_1234_5678, 1, a);
    chk("pass_accept", W'(a), W'(1));
    chk("pass_data", out_data, 64'hA5A5_0F0F_1234_5678);
    step(0, 0, '0, 1, a);
    chk("pass_drained", W'(out_valid), '0);

    // streaming at full rate
    for (int i = 0; i < 100; i++) begin
      step(0, 1, W'(i), 1, a);
      chk("stream_accept", W'(a), W'(1));
      chk("stream_data", out_data, W'(i));
    end
    step(0, 0, '0, 1, a);

    // back-pressure fill then drain
    step(0, 1, W'(1), 0, a);
    chk("bp_acc1", W'(a), W'(1));
    step(0, 1, W'(2), 0, a);
    chk("bp_acc2", W'(a), W'(1));
    chk("bp_occ2", W'(occupancy), W'(2));
    step(0, 1, W'(3), 0, a);
    chk("bp_refuse3", W'(a), '0);
    chk("bp_front1", out_data, W'(1));
    step(0, 1, W'(3), 1, a);
    chk("bp_refuse3_again", W'(a), '0);
    chk("bp_front2", out_data, W'(2));
    step(0, 1, W'(3), 1, a);
    chk("bp_acc3", W'(a), W'(1));
    chk("bp_front3", out_data, W'(3));
    step(0, 0, '0, 1, a);
    chk("bp_empty", W'(occupancy), '0);

    // random stall with a source that holds data until accepted
    src_pending = 1'b0;
    src = '0;
    for (int i = 0; i < 10000; i++) begin
      if (!src_pending) begin
        src = {$urandom, $urandom};
        src_pending = 1'b1;
      end
      step(0, 1'($urandom_range(0, 1)), src, 1'($urandom_range(0, 1)), a);
      if (a) src_pending = 1'b0;
    end

    // reset while full: buffered vectors are discarded
    for (int i = 0; i < 4; i++) step(0, 1, W'(32'hBEEF_0000 + i), 0, a);
    chk("mid_full", W'(occupancy), W'(2));
    step(1, 1, W'(32'hDEAD), 1, a);
    chk("mid_rst_occ", W'(occupancy), '0);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1, a);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
